// File: rtl/sa_ram_rws_param.sv
// Parametrised 1R/1W synchronous RAM with lane write mask, reset-time clear,
// selectable read-during-write result and optional output register.
module sa_ram_rws_param #(
    parameter int DEPTH       = 32,
    parameter int AW          = 5,
    parameter int WIDTH       = 128,
    parameter int GRAN        = 8,
    parameter int OUT_REG     = 0,
    parameter int RDW_NEW     = 0,
    parameter int INIT_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         ra,
    input  logic                  re,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_vld,
    input  logic [AW-1:0]         wa,
    input  logic                  we,
    input  logic [WIDTH/GRAN-1:0] wmask,
    input  logic [WIDTH-1:0]      di,
    output logic                  init_done,
    input  logic [31:0]           pwrbus_ram_pd
);
    localparam int LANES = WIDTH / GRAN;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) state_d = ST_READY;
            end
            ST_IDLE: state_d = ST_READY;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_ON_RST != 0) ? ST_INIT : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic ready;
    logic init_we;
    logic wr_acc;
    logic rd_acc;
    logic rd_in;
    logic rdw_hit;
    logic [IW-1:0] wa_idx;
    logic [IW-1:0] ra_idx;
    logic [IW-1:0] cnt_idx;

    assign ready     = (state_q == ST_READY);
    assign init_done = ready;
    assign init_we   = (state_q == ST_INIT);
    assign wa_idx    = wa[IW-1:0];
    assign ra_idx    = ra[IW-1:0];
    assign cnt_idx   = cnt_q[IW-1:0];
    assign wr_acc    = ready & we & ({1'b0, wa} < DEPTH_W);
    assign rd_acc    = ready & re;
    assign rd_in     = ({1'b0, ra} < DEPTH_W);
    assign rdw_hit   = wr_acc & (wa == ra);

    // Per-bit expansion of the lane mask, used for the read-during-write merge.
    logic [WIDTH-1:0] wbits;
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wbits[gi*GRAN +: GRAN] = {GRAN{wmask[gi]}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[cnt_idx] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) mem[wa_idx][i*GRAN +: GRAN] <= di[i*GRAN +: GRAN];
            end
        end
    end

    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] rd_data_d;
    assign rd_word = mem[ra_idx];

    always_comb begin
        rd_data_d = rd_word;
        if (!rd_in)
            rd_data_d = '0;
        else if ((RDW_NEW != 0) && rdw_hit)
            rd_data_d = (rd_word & ~wbits) | (di & wbits);
    end

    // Data registers only load on an accepted read, so dout holds otherwise.
    logic             vld1_q;
    logic [WIDTH-1:0] data1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld1_q  <= 1'b0;
            data1_q <= '0;
        end else begin
            vld1_q <= rd_acc;
            if (rd_acc) data1_q <= rd_data_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic             vld2_q;
            logic [WIDTH-1:0] data2_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld2_q  <= 1'b0;
                    data2_q <= '0;
                end else begin
                    vld2_q <= vld1_q;
                    if (vld1_q) data2_q <= data1_q;
                end
            end
            assign dout     = data2_q;
            assign dout_vld = vld2_q;
        end else begin : g_noreg
            assign dout     = data1_q;
            assign dout_vld = vld1_q;
        end
    endgenerate

    logic unused_pwr;
    assign unused_pwr = ^pwrbus_ram_pd;
endmodule
